arb_rr_hold: RTL and testbench



---
 rtl/arb_rr_hold.sv | 119 +++++++++++
 tb/tb_arb_rr_hold.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/arb_rr_hold.sv
// Work-conserving round-robin arbiter with a registered grant held until the owner releases.
// Optional owner preemption after MAX_HOLD cycles under contention: define ARB_RR_TIMEOUT_EN.
module arb_rr_hold #(
    parameter int PORTS_NUM = 4,
    parameter int IDX_W     = 2,
    parameter int MAX_HOLD  = 16,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PORTS_NUM-1:0] req,
    output logic [PORTS_NUM-1:0] gnt,
    output logic [IDX_W-1:0]     gnt_idx,
    output logic                 gnt_vld
);

    if (PORTS_NUM < 2 || PORTS_NUM > 32 || IDX_W < $clog2(PORTS_NUM) || MAX_HOLD < 1 ||
        (CNT_W < 31 && MAX_HOLD > (1 << CNT_W))) begin : g_bad_param
        $error("arb_rr_hold: illegal parameter combination");
    end

    typedef enum logic {IDLE, GRANT} state_t;

    state_t               state_q;
    logic [PORTS_NUM-1:0] gnt_q;
    logic [IDX_W-1:0]     idx_q;
    logic [IDX_W-1:0]     ptr_q;
    logic [CNT_W-1:0]     hold_q;

    logic [PORTS_NUM-1:0] cand;
    logic                 owner_req;
    logic                 win_vld;
    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W-1:0]     win_nptr;
    logic [PORTS_NUM-1:0] win_oh;

    // The current owner never competes: on release its req is already low, on preemption it must be skipped.
    assign cand      = req & ~gnt_q;
    assign owner_req = |(req & gnt_q);

    // Scan from the farthest slot back toward ptr so the last hit is the highest-priority requester.
    always_comb begin
        int p;
        p        = 0;
        win_vld  = 1'b0;
        win_idx  = '0;
        win_nptr = '0;
        win_oh   = '0;
        for (int i = PORTS_NUM - 1; i >= 0; i--) begin
            p = int'(ptr_q) + i;
            if (p >= PORTS_NUM) p = p - PORTS_NUM;
            if (cand[p]) begin
                win_vld  = 1'b1;
                win_idx  = IDX_W'(p);
                win_nptr = (p == PORTS_NUM - 1) ? '0 : IDX_W'(p + 1);
                win_oh   = '0;
                win_oh[p] = 1'b1;
            end
        end
    end

`ifdef ARB_RR_TIMEOUT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_vld) begin
                        state_q <= GRANT;
                        gnt_q   <= win_oh;
                        idx_q   <= win_idx;
                        ptr_q   <= win_nptr;
                        hold_q  <= '0;
                    end
                end
                GRANT: begin
                    if (!owner_req) begin
                        if (win_vld) begin
                            gnt_q  <= win_oh;
                            idx_q  <= win_idx;
                            ptr_q  <= win_nptr;
                            hold_q <= '0;
                        end else begin
                            state_q <= IDLE;
                            gnt_q   <= '0;
                            idx_q   <= '0;
                            hold_q  <= '0;
                        end
`ifdef ARB_RR_TIMEOUT_EN
                    end else if (hold_q == HOLD_LAST) begin
                        hold_q <= '0;
                        if (win_vld) begin
                            gnt_q <= win_oh;
                            idx_q <= win_idx;
                            ptr_q <= win_nptr;
                        end
`endif
                    end else if (hold_q != '1) begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = idx_q;
    assign gnt_vld = |gnt_q;

endmodule

// File: tb/tb_arb_rr_hold.sv
// Directed bench for arb_rr_hold: reset, hold, rotation, skip/wrap, mid-grant reset, handover.
module tb_arb_rr_hold;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_vld;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    arb_rr_hold #(.PORTS_NUM(4), .IDX_W(2), .MAX_HOLD(4), .CNT_W(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .gnt    (gnt),
        .gnt_idx(gnt_idx),
        .gnt_vld(gnt_vld)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req   = 4'b0000;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req   = 4'b1111;
        tick();
        tick();
        chk_cnt++;
        if (gnt !== 4'b0000 || gnt_idx !== 2'd0 || gnt_vld !== 1'b0)
            $display("FAIL reset_outputs gnt=%b idx=%0d vld=%b want 0000/0/0", gnt, gnt_idx, gnt_vld);
        else pass_cnt++;
        chk_cnt++;
        if (dut.ptr_q !== 2'd0) $display("FAIL reset_ptr got %0d want 0", dut.ptr_q);
        else pass_cnt++;
        reset = 1'b1;
        req   = 4'b0000;
        tick();
    endtask

    task automatic test_single_hold();
        do_reset();
        req = 4'b0100;
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk_cnt++;
            if (gnt !== 4'b0100 || gnt_idx !== 2'd2 || gnt_vld !== 1'b1)
                $display("FAIL hold_c%0d gnt=%b idx=%0d vld=%b want 0100/2/1", c, gnt, gnt_idx, gnt_vld);
            else pass_cnt++;
        end
        req = 4'b0000;
        tick();
        chk_cnt++;
        if (gnt !== 4'b0000 || gnt_vld !== 1'b0)
            $display("FAIL hold_release gnt=%b vld=%b want 0000/0", gnt, gnt_vld);
        else pass_cnt++;
        chk_cnt++;
        if (dut.ptr_q !== 2'd3) $display("FAIL hold_ptr got %0d want 3", dut.ptr_q);
        else pass_cnt++;
    endtask

    task automatic test_rotation();
        logic [3:0] exp;
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            exp = 4'b0001 << k;
            for (int c = 0; c < 3; c++) begin
                tick();
                chk_cnt++;
                if (gnt !== exp || gnt_idx !== 2'(k) || gnt_vld !== 1'b1)
                    $display("FAIL rotate_o%0d_c%0d gnt=%b idx=%0d want %b/%0d", k, c, gnt, gnt_idx, exp, k);
                else pass_cnt++;
            end
            req[k] = 1'b0;
        end
        tick();
        chk_cnt++;
        if (gnt !== 4'b0000 || gnt_vld !== 1'b0)
            $display("FAIL rotate_idle gnt=%b vld=%b want 0000/0", gnt, gnt_vld);
        else pass_cnt++;
    endtask

    task automatic test_skip_wrap();
        do_reset();
        req = 4'b1000;
        tick();
        chk_cnt++;
        if (gnt !== 4'b1000 || gnt_idx !== 2'd3 || gnt_vld !== 1'b1)
            $display("FAIL skip_p3 gnt=%b idx=%0d want 1000/3", gnt, gnt_idx);
        else pass_cnt++;
        req = 4'b0000;
        tick();
        chk_cnt++;
        if (gnt !== 4'b0000) $display("FAIL skip_release gnt=%b want 0000", gnt);
        else pass_cnt++;
        req = 4'b1001;
        tick();
        chk_cnt++;
        if (gnt !== 4'b0001 || gnt_idx !== 2'd0)
            $display("FAIL wrap_p0 gnt=%b idx=%0d want 0001/0", gnt, gnt_idx);
        else pass_cnt++;
        req = 4'b1000;
        tick();
        chk_cnt++;
        if (gnt !== 4'b1000 || gnt_idx !== 2'd3)
            $display("FAIL wrap_handover gnt=%b idx=%0d want 1000/3", gnt, gnt_idx);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 4'b0010;
        tick();
        tick();
        chk_cnt++;
        if (gnt !== 4'b0010) $display("FAIL midrst_pre gnt=%b want 0010", gnt);
        else pass_cnt++;
        reset = 1'b0;
        tick();
        chk_cnt++;
        if (gnt !== 4'b0000 || gnt_vld !== 1'b0 || gnt_idx !== 2'd0)
            $display("FAIL midrst_drop gnt=%b idx=%0d vld=%b want 0000/0/0", gnt, gnt_idx, gnt_vld);
        else pass_cnt++;
        reset = 1'b1;
        tick();
        chk_cnt++;
        if (gnt !== 4'b0010 || gnt_idx !== 2'd1 || gnt_vld !== 1'b1)
            $display("FAIL midrst_regrant gnt=%b idx=%0d want 0010/1", gnt, gnt_idx);
        else pass_cnt++;
        chk_cnt++;
        if (dut.ptr_q !== 2'd2) $display("FAIL midrst_ptr got %0d want 2", dut.ptr_q);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        req = 4'b0001;
        tick();
        req = 4'b0000;
        tick();
        chk_cnt++;
        if (gnt !== 4'b0000) $display("FAIL rereq_gap gnt=%b want 0000", gnt);
        else pass_cnt++;
        req = 4'b0001;
        tick();
        chk_cnt++;
        if (gnt !== 4'b0001) $display("FAIL rereq_win gnt=%b want 0001", gnt);
        else pass_cnt++;
        req = 4'b0111;
        tick();
        tick();
        chk_cnt++;
        if (gnt !== 4'b0001) $display("FAIL nodisturb gnt=%b want 0001", gnt);
        else pass_cnt++;
        req = 4'b0110;
        tick();
        chk_cnt++;
        if (gnt !== 4'b0010 || gnt_idx !== 2'd1)
            $display("FAIL b2b_p1 gnt=%b idx=%0d want 0010/1", gnt, gnt_idx);
        else pass_cnt++;
        req = 4'b1100;
        tick();
        chk_cnt++;
        if (gnt !== 4'b0100 || gnt_idx !== 2'd2)
            $display("FAIL b2b_p2 gnt=%b idx=%0d want 0100/2", gnt, gnt_idx);
        else pass_cnt++;
        req = 4'b1001;
        tick();
        chk_cnt++;
        if (gnt !== 4'b1000 || gnt_idx !== 2'd3)
            $display("FAIL b2b_p3 gnt=%b idx=%0d want 1000/3", gnt, gnt_idx);
        else pass_cnt++;
        req = 4'b0000;
        tick();
    endtask

`ifdef ARB_RR_TIMEOUT_EN
    task automatic test_timeout();
        logic [3:0] exp;
        do_reset();
        req = 4'b0011;
        for (int r = 0; r < 4; r++) begin
            exp = (r % 2 == 0) ? 4'b0001 : 4'b0010;
            for (int c = 0; c < 4; c++) begin
                tick();
                chk_cnt++;
                if (gnt !== exp) $display("FAIL tmo_alt_r%0d_c%0d gnt=%b want %b", r, c, gnt, exp);
                else pass_cnt++;
            end
        end
        do_reset();
        req = 4'b0001;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk_cnt++;
            if (gnt !== 4'b0001) $display("FAIL tmo_solo_c%0d gnt=%b want 0001", c, gnt);
            else pass_cnt++;
        end
        req = 4'b0000;
        tick();
    endtask
`endif

    initial begin
        reset = 1'b0;
        req   = 4'b0000;
        test_reset();
        test_single_hold();
        test_rotation();
        test_skip_wrap();
        test_reset_mid_grant();
        test_back_to_back();
`ifdef ARB_RR_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
